frame_capture_ctrl: RTL and testbench

//  Sequences camera-pixel writes into the dual-port frame buffer (write port A) in the camera clock domain.

---
 rtl/cam_pkg.sv | 12 +
 rtl/fb_addr_gen.sv | 41 ++++
 rtl/frame_capture_ctrl.sv | 121 ++++++++++++
 tb/tb_frame_capture_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared camera-domain types and widths for the capture path.
package cam_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    localparam int CAM_H_W  = 11;
    localparam int CAM_V_W  = 10;
    localparam int RGB565_W = 16;
endpackage

// File: rtl/fb_addr_gen.sv
// Combinational decimation filter: pixel coordinates -> keep flag, buffer address, last-pixel flag.
module fb_addr_gen
    import cam_pkg::*;
#(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 180,
    parameter int H_DEC_LOG2 = 2,
    parameter int V_DEC_LOG2 = 2,
    localparam int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic               pixel_valid_in,
    input  logic [CAM_H_W-1:0] hcount_in,
    input  logic [CAM_V_W-1:0] vcount_in,
    output logic               keep_out,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               is_last_out
);
    localparam int MUL_W = CAM_H_W + CAM_V_W;
    localparam logic [CAM_H_W-1:0] H_MASK = CAM_H_W'((1 << H_DEC_LOG2) - 1);
    localparam logic [CAM_V_W-1:0] V_MASK = CAM_V_W'((1 << V_DEC_LOG2) - 1);
    localparam logic [MUL_W-1:0] LAST_ADDR = MUL_W'(FB_WIDTH * FB_HEIGHT - 1);

    logic [MUL_W-1:0] h_idx;
    logic [MUL_W-1:0] v_idx;
    logic [MUL_W-1:0] full_addr;

    assign h_idx = MUL_W'(hcount_in >> H_DEC_LOG2);
    assign v_idx = MUL_W'(vcount_in >> V_DEC_LOG2);

    // Address comes from coordinates, so a missing pixel leaves a hole instead of shifting the image.
    assign full_addr = v_idx * MUL_W'(FB_WIDTH) + h_idx;

    assign keep_out = pixel_valid_in
                   && ((hcount_in & H_MASK) == '0)
                   && ((vcount_in & V_MASK) == '0)
                   && (h_idx < MUL_W'(FB_WIDTH))
                   && (v_idx < MUL_W'(FB_HEIGHT));

    assign addr_out    = full_addr[ADDR_W-1:0];
    assign is_last_out = keep_out && (full_addr == LAST_ADDR);
endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame-aligned capture sequencer driving frame buffer write port A in the camera clock domain.
// Supports continuous capture and single-shot snapshots with one queued request.
module frame_capture_ctrl
    import cam_pkg::*;
#(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 180,
    parameter int H_DEC_LOG2 = 2,
    parameter int V_DEC_LOG2 = 2,
    parameter int DATA_W     = RGB565_W,
    localparam int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               pixel_valid_in,
    input  logic [CAM_H_W-1:0] hcount_in,
    input  logic [CAM_V_W-1:0] vcount_in,
    input  logic [DATA_W-1:0]  pixel_in,
    input  logic               mode_in,
    input  logic               capture_req_in,
    output logic [ADDR_W-1:0]  bram_addr_out,
    output logic               bram_we_out,
    output logic [DATA_W-1:0]  bram_din_out,
    output logic               busy_out,
    output logic               frame_done_out,
    output logic [7:0]         frame_count_out,
    output cap_state_t         state_dbg_out
);
    // pixel_valid_in is a strobe with no back-pressure: a pixel is consumed in the
    // cycle it is valid, and its write appears on port A exactly one cycle later.
    cap_state_t        state_q, state_d;
    logic              req_latch_q, req_latch_d;
    logic              keep;
    logic              is_last;
    logic              sof;
    logic              write_d;
    logic              done_d;
    logic [ADDR_W-1:0] pix_addr;

    fb_addr_gen #(
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT),
        .H_DEC_LOG2 (H_DEC_LOG2),
        .V_DEC_LOG2 (V_DEC_LOG2)
    ) u_addr_gen (
        .pixel_valid_in (pixel_valid_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .keep_out       (keep),
        .addr_out       (pix_addr),
        .is_last_out    (is_last)
    );

    assign sof = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);

    always_comb begin
        state_d     = state_q;
        req_latch_d = req_latch_q;
        write_d     = 1'b0;
        done_d      = 1'b0;

        // Requests arriving while busy queue at most one snapshot.
        if (state_q != IDLE && capture_req_in) begin
            req_latch_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!mode_in || capture_req_in || req_latch_q) begin
                    state_d     = ARMED;
                    req_latch_d = 1'b0;
                end
            end
            ARMED: begin
                if (sof && keep) begin
                    write_d = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (keep) begin
                    write_d = 1'b1;
                    // A fresh SOF before LAST restarts the frame without a done pulse.
                    if (!sof && is_last) begin
                        done_d  = 1'b1;
                        state_d = mode_in ? IDLE : ARMED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            req_latch_q     <= 1'b0;
            bram_addr_out   <= '0;
            bram_we_out     <= 1'b0;
            bram_din_out    <= '0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
            frame_count_out <= 8'd0;
        end else begin
            state_q        <= state_d;
            req_latch_q    <= req_latch_d;
            bram_we_out    <= write_d;
            frame_done_out <= done_d;
            busy_out       <= (state_d != IDLE);
            if (write_d) begin
                bram_addr_out <= pix_addr;
                bram_din_out  <= pixel_in;
            end
            if (done_d) begin
                frame_count_out <= frame_count_out + 8'd1;
            end
        end
    end

    assign state_dbg_out = state_q;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: reduced-size instance with a coordinate scoreboard,
// plus a default-size instance pinning the full-resolution address arithmetic.
module tb_frame_capture_ctrl;
    import cam_pkg::*;

    localparam int FBW    = 10;
    localparam int FBH    = 6;
    localparam int HD     = 2;
    localparam int VD     = 2;
    localparam int DW     = 16;
    localparam int AW     = $clog2(FBW * FBH);
    localparam int EW     = AW + DW + 1;
    localparam int RW     = 48;
    localparam int RH     = 28;
    localparam int LAST_A = FBW * FBH - 1;

    // clock / reset
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic          rst, pv, mode, req;
    logic [10:0]   hc;
    logic [9:0]    vc;
    logic [DW-1:0] pix;
    logic [AW-1:0] addr;
    logic          we, busy, done;
    logic [DW-1:0] din;
    logic [7:0]    fc;
    cap_state_t    st;

    frame_capture_ctrl #(
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .H_DEC_LOG2(HD), .V_DEC_LOG2(VD), .DATA_W(DW)
    ) dut (
        .clk_in(clk), .rst_in(rst), .pixel_valid_in(pv), .hcount_in(hc), .vcount_in(vc),
        .pixel_in(pix), .mode_in(mode), .capture_req_in(req),
        .bram_addr_out(addr), .bram_we_out(we), .bram_din_out(din), .busy_out(busy),
        .frame_done_out(done), .frame_count_out(fc), .state_dbg_out(st)
    );

    // default-size instance
    logic          b_rst, b_pv, b_mode, b_req;
    logic [10:0]   b_hc;
    logic [9:0]    b_vc;
    logic [15:0]   b_pix;
    logic [15:0]   b_addr;
    logic          b_we, b_busy, b_done;
    logic [15:0]   b_din;
    logic [7:0]    b_fc;
    cap_state_t    b_st;

    frame_capture_ctrl dut_big (
        .clk_in(clk), .rst_in(b_rst), .pixel_valid_in(b_pv), .hcount_in(b_hc), .vcount_in(b_vc),
        .pixel_in(b_pix), .mode_in(b_mode), .capture_req_in(b_req),
        .bram_addr_out(b_addr), .bram_we_out(b_we), .bram_din_out(b_din), .busy_out(b_busy),
        .frame_done_out(b_done), .frame_count_out(b_fc), .state_dbg_out(b_st)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    bit            chk_en = 1'b0;
    logic [7:0]    exp_fc = 8'd0;
    logic [DW-1:0] pix_val = 16'h0100;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cur_e;
    int            wr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // model: decimation and coordinate rules
    function automatic bit model_keep(input int h, input int v);
        return (h % (1 << HD) == 0) && (v % (1 << VD) == 0)
            && (h / (1 << HD) < FBW) && (v / (1 << VD) < FBH);
    endfunction

    function automatic int model_addr(input int h, input int v);
        return (v / (1 << VD)) * FBW + h / (1 << HD);
    endfunction

    // scoreboard / compare process
    always @(negedge clk) begin
        if (chk_en) begin
            if (we) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0d din %0d, no write expected", addr, din);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk("wr_addr", 32'(addr), 32'(cur_e[DW +: AW]));
                    chk("wr_din", 32'(din), 32'(cur_e[DW-1:0]));
                    chk("done_on_last", 32'(done), 32'(cur_e[EW-1]));
                    if (cur_e[EW-1]) exp_fc = exp_fc + 8'd1;
                end
                wr_log.push_back(int'(addr));
            end else begin
                chk("done_without_write", 32'(done), 0);
            end
            chk("frame_count", 32'(fc), 32'(exp_fc));
            chk("busy_vs_state", 32'(busy), 32'(st != IDLE));
        end
    end

    // driver tasks
    task automatic drive(input bit v, input int h, input int vv, input logic [DW-1:0] d, input bit r);
        @(posedge clk);
        #1;
        pv  = v;
        hc  = 11'(h);
        vc  = 10'(vv);
        pix = d;
        req = r;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, '0, 1'b0);
    endtask

    task automatic send_frame(input bit cap, input int stop_v, input int drop_h, input int drop_v,
                              input bit gaps, input int req_v1, input int req_v2,
                              input int mode_v, input bit mode_new);
        for (int v = 0; v < RH; v++) begin
            if (v == stop_v) return;
            for (int h = 0; h < RW; h++) begin
                bit r;
                int a;
                r = (h == 0) && (v == req_v1 || v == req_v2);
                a = model_addr(h, v);
                if (h == 0 && v == mode_v) mode = mode_new;
                if (gaps && ((h + v) % 7 == 3)) drive(1'b0, h, v, '0, 1'b0);
                if (h == drop_h && v == drop_v) begin
                    drive(1'b0, h, v, pix_val, r);
                end else begin
                    if (cap && model_keep(h, v)) exp_q.push_back({a == LAST_A, AW'(a), pix_val});
                    drive(1'b1, h, v, pix_val, r);
                end
                pix_val++;
            end
        end
    endtask

    task automatic full(input bit cap);
        send_frame(cap, -1, -1, -1, 1'b0, -1, -1, -1, 1'b0);
    endtask

    task automatic big_drive(input bit v, input int h, input int vv, input logic [15:0] d);
        @(posedge clk);
        #1;
        b_pv  = v;
        b_hc  = 11'(h);
        b_vc  = 10'(vv);
        b_pix = d;
    endtask

    initial begin
        int c22;
        rst = 1'b1; pv = 1'b0; hc = '0; vc = '0; pix = '0; mode = 1'b0; req = 1'b0;
        b_rst = 1'b1; b_pv = 1'b0; b_hc = '0; b_vc = '0; b_pix = '0; b_mode = 1'b0; b_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_din", 32'(din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(fc), 0);
        chk("rst_state", 32'(st), 32'(IDLE));
        chk_en = 1'b1;
        rst    = 1'b0;

        // continuous capture, two frames
        idle(2);
        wr_log.delete();
        full(1'b1);
        idle(3);
        chk("f1_writes", 32'(wr_log.size()), 60);
        chk("f1_first_addr", 32'(wr_log[0]), 0);
        chk("f1_addr_h4_v4", 32'(wr_log[11]), 11);
        chk("f1_last_addr", 32'(wr_log[59]), 59);
        chk("f1_count", 32'(fc), 1);
        wr_log.delete();
        full(1'b1);
        idle(3);
        chk("f2_writes", 32'(wr_log.size()), 60);
        chk("f2_count", 32'(fc), 2);

        // valid gaps and one dropped kept pixel at (8,8) -> address 22
        wr_log.delete();
        send_frame(1'b1, -1, 8, 8, 1'b1, -1, -1, -1, 1'b0);
        idle(3);
        c22 = 0;
        foreach (wr_log[i]) if (wr_log[i] == 22) c22++;
        chk("drop_writes", 32'(wr_log.size()), 59);
        chk("drop_addr22_absent", 32'(c22), 0);
        chk("drop_count", 32'(fc), 3);

        // truncated frame: SOF injected at row 12
        wr_log.delete();
        send_frame(1'b1, 12, -1, -1, 1'b0, -1, -1, -1, 1'b0);
        full(1'b1);
        idle(3);
        chk("trunc_writes", 32'(wr_log.size()), 90);
        chk("trunc_restart_addr", 32'(wr_log[30]), 0);
        chk("trunc_count", 32'(fc), 4);

        // reset mid-frame at row 16
        send_frame(1'b1, 16, -1, -1, 1'b0, -1, -1, -1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; pv = 1'b0; req = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_fc = 8'd0;
        chk("rst_mid_we", 32'(we), 0);
        chk("rst_mid_count", 32'(fc), 0);
        chk("rst_mid_state", 32'(st), 32'(IDLE));
        chk("rst_mid_pending", 32'(exp_q.size()), 0);
        idle(2);
        // resume, with a mid-frame switch to single-shot that must not truncate
        wr_log.delete();
        send_frame(1'b1, -1, -1, -1, 1'b0, -1, -1, 8, 1'b1);
        idle(3);
        chk("resume_writes", 32'(wr_log.size()), 60);
        chk("resume_count", 32'(fc), 1);
        chk("resume_state", 32'(st), 32'(IDLE));
        chk("resume_busy", 32'(busy), 0);

        // single-shot: request mid-frame, capture exactly the next frame
        wr_log.delete();
        send_frame(1'b0, -1, -1, -1, 1'b0, 10, -1, -1, 1'b1);
        idle(3);
        chk("ss_no_early_writes", 32'(wr_log.size()), 0);
        chk("ss_armed", 32'(st), 32'(ARMED));
        full(1'b1);
        idle(3);
        chk("ss_writes", 32'(wr_log.size()), 60);
        chk("ss_count", 32'(fc), 2);
        chk("ss_idle", 32'(st), 32'(IDLE));
        chk("ss_busy", 32'(busy), 0);
        full(1'b0);
        idle(3);
        chk("ss_after_writes", 32'(wr_log.size()), 60);

        // two requests during capture queue exactly one extra frame
        send_frame(1'b0, -1, -1, -1, 1'b0, 20, -1, -1, 1'b1);
        wr_log.delete();
        send_frame(1'b1, -1, -1, -1, 1'b0, 4, 12, -1, 1'b1);
        full(1'b1);
        full(1'b0);
        idle(3);
        chk("queue_writes", 32'(wr_log.size()), 120);
        chk("queue_count", 32'(fc), 4);
        chk("queue_idle", 32'(st), 32'(IDLE));
        chk("queue_busy", 32'(busy), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);

        // full-resolution instance: SOF, (4,4), last pixel, out-of-range pixel
        b_rst = 1'b0;
        big_drive(1'b0, 0, 0, 16'h0);
        big_drive(1'b0, 0, 0, 16'h0);
        big_drive(1'b1, 0, 0, 16'hA001);
        big_drive(1'b1, 4, 4, 16'hA002);
        chk("big_sof_we", 32'(b_we), 1);
        chk("big_sof_addr", 32'(b_addr), 0);
        chk("big_sof_din", 32'(b_din), 32'h0000A001);
        big_drive(1'b1, 1276, 716, 16'hA003);
        chk("big_h4v4_addr", 32'(b_addr), 321);
        chk("big_h4v4_din", 32'(b_din), 32'h0000A002);
        chk("big_capture", 32'(b_st), 32'(CAPTURE));
        big_drive(1'b1, 1280, 0, 16'hA004);
        chk("big_last_we", 32'(b_we), 1);
        chk("big_last_addr", 32'(b_addr), 57599);
        chk("big_last_done", 32'(b_done), 1);
        chk("big_last_count", 32'(b_fc), 1);
        big_drive(1'b0, 0, 0, 16'h0);
        chk("big_oob_we", 32'(b_we), 0);
        chk("big_oob_done", 32'(b_done), 0);
        chk("big_rearmed", 32'(b_st), 32'(ARMED));
        chk("big_busy", 32'(b_busy), 1);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
